control_sequencer: RTL

- Moore FSM that drives every control input of the datapath: clk/clr, read/write, register-out strobes, register-in strobes, Gra/Grb/Grc, BAout and the ALU op selects.
- Replaces the hand-sequenced T-state stimulus.
- Runs fetch (T0–T2), decodes IR[31:27], then steps an opcode-specific execute sequence, one state per clock.
- Supports halt and an external stop/pause.

---
 rtl/control_sequencer_pkg.sv | 73 +++++++
 rtl/control_sequencer_if.sv | 17 +
 rtl/control_sequencer_opcode_decoder.sv | 43 ++++
 rtl/control_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: opcodes, FSM states, op classes, strobe bundle.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
package control_sequencer_pkg;

  localparam int OP_W = 5;
  localparam int IR_W = 32;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // T0..T7 are consecutive so the step counter can advance by +1.
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_MULDIV, C_LDI, C_LD, C_ST, C_BR, C_JR,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic add_op;
    logic sub_op;
    logic mul_op;
    logic div_op;
    logic and_op;
    logic or_op;
  } alu_sel_t;

  // Every datapath control line plus the sequencer status bits.
  typedef struct packed {
    logic PCout;  logic Zlowout; logic Zhighout; logic MDRout; logic Cout;
    logic IN_Portout; logic LOout; logic HIout; logic BAout; logic Rout;
    logic MARIn;  logic PCIn;   logic MDRIn;  logic IRIn;  logic YIn;
    logic IncPC;  logic HiIn;   logic LoIn;   logic CIn;   logic InIn;
    logic OutIn;  logic ZIn;    logic CONIn;  logic RIn;
    logic Gra;    logic Grb;    logic Grc;
    logic read;   logic write;
    logic add;    logic subtract; logic multiply; logic divide;
    logic andSignal; logic orSignal;
    logic run;    logic illegal_op;
  } ctrl_t;

  // Final execute step of each op class; the instruction boundary follows it.
  function automatic state_e last_step(input op_class_e c);
    case (c)
      C_ALU_R, C_ALU_I, C_LDI: return S_T5;
      C_MULDIV, C_BR:          return S_T6;
      C_LD, C_ST:              return S_T7;
      default:                 return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between sequencer and datapath: IR/CON/stop into the sequencer, strobes out.
// Latency: n/a (wires only).
// Backpressure: none; strobes are asserted unconditionally each cycle.
interface control_sequencer_if #(
  parameter int IRW = control_sequencer_pkg::IR_W
);
  import control_sequencer_pkg::*;

  logic [IRW-1:0] ir;
  logic           con_ff;
  logic           stop;
  ctrl_t          ctrl;

  modport master (input ir, con_ff, stop, output ctrl);
  modport slave  (output ir, con_ff, stop, input ctrl);

endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Maps the opcode field to an op class and the ALU function it selects.
// Latency: combinational.
// Backpressure: none.
module control_sequencer_opcode_decoder
  import control_sequencer_pkg::*;
#(
  parameter int OPW = OP_W
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class,
  output alu_sel_t       alu_sel
);

  // Opcode lookup; anything not listed is reported as illegal
  always_comb begin
    op_class = C_ILLEGAL;
    alu_sel  = '0;
    case (opcode)
      OP_LD:   op_class = C_LD;
      OP_LDI:  op_class = C_LDI;
      OP_ST:   op_class = C_ST;
      OP_ADD:  begin op_class = C_ALU_R;  alu_sel.add_op = 1'b1; end
      OP_SUB:  begin op_class = C_ALU_R;  alu_sel.sub_op = 1'b1; end
      OP_AND:  begin op_class = C_ALU_R;  alu_sel.and_op = 1'b1; end
      OP_OR:   begin op_class = C_ALU_R;  alu_sel.or_op  = 1'b1; end
      OP_ADDI: begin op_class = C_ALU_I;  alu_sel.add_op = 1'b1; end
      OP_ANDI: begin op_class = C_ALU_I;  alu_sel.and_op = 1'b1; end
      OP_ORI:  begin op_class = C_ALU_I;  alu_sel.or_op  = 1'b1; end
      OP_MUL:  begin op_class = C_MULDIV; alu_sel.mul_op = 1'b1; end
      OP_DIV:  begin op_class = C_MULDIV; alu_sel.div_op = 1'b1; end
      OP_BR:   op_class = C_BR;
      OP_JR:   op_class = C_JR;
      OP_IN:   op_class = C_IN;
      OP_OUT:  op_class = C_OUT;
      OP_MFHI: op_class = C_MFHI;
      OP_MFLO: op_class = C_MFLO;
      OP_NOP:  op_class = C_NOP;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore FSM sequencing fetch (T0-T2) and per-class execute steps (T3-T7) for the datapath.
// Latency: 4 to 8 clocks per instruction from T0 through its last execute step.
// Backpressure: stop parks the FSM in PAUSE at the next instruction boundary only.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int IRW = IR_W
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d, dec_cls, cur_cls;
  alu_sel_t  alu_q, alu_d, dec_alu, cur_alu;
  ctrl_t     ctrl;
  logic      ir_unused;

  assign ir_unused = ^bus.ir[IRW-OPW-1:0];

  control_sequencer_opcode_decoder #(.OPW(OPW)) u_opcode_decoder (
    .opcode   (bus.ir[IRW-1 -: OPW]),
    .op_class (dec_cls),
    .alu_sel  (dec_alu)
  );

  // Class is decoded live in T3 (IR just loaded) and held for the later steps
  always_comb begin
    cur_cls = cls_q;
    cur_alu = alu_q;
    if (state_q == S_T3) begin
      cur_cls = dec_cls;
      cur_alu = dec_alu;
    end
    cls_d = cur_cls;
    alu_d = cur_alu;
  end

  // Next state: linear fetch, class-dependent execute length, boundary check on stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == S_T3 && cur_cls == C_HALT)  state_d = S_HALT;
        else if (state_q == last_step(cur_cls))    state_d = bus.stop ? S_PAUSE : S_T0;
        else                                       state_d = state_e'(state_q + 4'd1);
      end
      S_PAUSE: state_d = bus.stop ? S_PAUSE : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State and held decode; clr low aborts whatever was in flight
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_RESET;
      cls_q   <= C_NOP;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
    end
  end

  // Strobe decode from the current step and held op class
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_T0: begin ctrl.run = 1'b1; ctrl.PCout = 1'b1; ctrl.MARIn = 1'b1; ctrl.IncPC = 1'b1; ctrl.ZIn = 1'b1; end
      S_T1: begin ctrl.run = 1'b1; ctrl.Zlowout = 1'b1; ctrl.PCIn = 1'b1; ctrl.read = 1'b1; ctrl.MDRIn = 1'b1; end
      S_T2: begin ctrl.run = 1'b1; ctrl.MDRout = 1'b1; ctrl.IRIn = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        ctrl.run = 1'b1;
        case (cur_cls)
          C_ALU_R, C_ALU_I: begin
            case (state_q)
              S_T3: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.YIn = 1'b1; end
              S_T4: begin
                ctrl.ZIn = 1'b1;
                if (cur_cls == C_ALU_R) begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; end
                else                          ctrl.Cout = 1'b1;
                ctrl.add       = cur_alu.add_op;
                ctrl.subtract  = cur_alu.sub_op;
                ctrl.andSignal = cur_alu.and_op;
                ctrl.orSignal  = cur_alu.or_op;
              end
              S_T5: begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state_q)
              S_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.YIn = 1'b1; end
              S_T4: begin
                ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.ZIn = 1'b1;
                ctrl.multiply = cur_alu.mul_op;
                ctrl.divide   = cur_alu.div_op;
              end
              S_T5: begin ctrl.Zlowout = 1'b1; ctrl.LoIn = 1'b1; end
              S_T6: begin ctrl.Zhighout = 1'b1; ctrl.HiIn = 1'b1; end
              default: ;
            endcase
          end
          C_LDI, C_LD, C_ST: begin
            case (state_q)
              S_T3: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.YIn = 1'b1; end
              S_T4: begin ctrl.Cout = 1'b1; ctrl.add = 1'b1; ctrl.ZIn = 1'b1; end
              S_T5: begin
                ctrl.Zlowout = 1'b1;
                if (cur_cls == C_LDI) begin ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
                else                        ctrl.MARIn = 1'b1;
              end
              S_T6: begin
                ctrl.MDRIn = 1'b1;
                if (cur_cls == C_LD) ctrl.read = 1'b1;
                else begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; end
              end
              S_T7: begin
                if (cur_cls == C_LD) begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
                else                       ctrl.write = 1'b1;
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (state_q)
              S_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONIn = 1'b1; end
              S_T4: begin ctrl.PCout = 1'b1; ctrl.YIn = 1'b1; end
              S_T5: begin ctrl.Cout = 1'b1; ctrl.add = 1'b1; ctrl.ZIn = 1'b1; end
              S_T6: begin ctrl.Zlowout = 1'b1; ctrl.PCIn = bus.con_ff; end
              default: ;
            endcase
          end
          C_JR:      begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCIn = 1'b1; end
          C_IN:      begin ctrl.IN_Portout = 1'b1; ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
          C_OUT:     begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OutIn = 1'b1; end
          C_MFHI:    begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
          C_MFLO:    begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.RIn = 1'b1; end
          C_ILLEGAL: ctrl.illegal_op = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ctrl = ctrl;

endmodule
